// File: rtl/sram_like_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the sram-like arbiter slice: requester IDs stored in
// the order FIFO and the sram-like access-size encodings.
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    // Requester IDs as stored in the order FIFO.
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // sram-like access size field.
    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;

endpackage : sram_arb_pkg

// File: rtl/sram_like_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter_if
// One sram-like bus: request, write flag, size, address and write data flow
// from master to slave; read data, addr_ok and data_ok flow back.
//   master modport : the side that issues requests (the core, or the arbiter
//                    towards the AXI bridge)
//   slave modport  : the side that accepts them
// Parameters: ADDR_W address width, DATA_W data width.
// ----------------------------------------------------------------------------
interface sram_like_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req;
    logic              wr;
    size_t             size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              addr_ok;
    logic              data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );

endinterface : sram_like_arbiter_if

// File: rtl/sram_like_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// arb_order_fifo
// 1-bit wide, OUTSTANDING deep FIFO holding the requester ID of every
// accepted-but-unanswered transaction, oldest at the head.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   i_push        write i_push_id at the tail (ignored when full)
//   i_push_id     requester ID to record
//   i_pop         drop the head entry (ignored when empty)
//   o_head        ID of the oldest entry (valid while !o_empty)
//   o_count       number of stored entries, 0..OUTSTANDING
//   o_full        o_count == OUTSTANDING
//   o_empty       o_count == 0
// Parameters: OUTSTANDING depth, power of 2 and at least 2.
// ----------------------------------------------------------------------------
module arb_order_fifo #(
    parameter int OUTSTANDING = 4,
    localparam int PTR_W = $clog2(OUTSTANDING),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_push_id,
    input  logic             i_pop,
    output logic             o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic             r_mem [OUTSTANDING];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(OUTSTANDING));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Push together with pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, because r_count gates the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

endmodule : arb_order_fifo

// File: rtl/sram_like_arbiter.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter
// Shares one sram-like master port between the instruction and data
// sram-like requesters of the core. One address phase is granted at a time;
// the ID of every accepted address is queued so the in-order data_ok
// responses are steered back to the requester that issued them. Address and
// response paths are purely combinational (zero added latency).
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   inst_bus     instruction-side requester (slave modport)
//   data_bus     data-side requester (slave modport)
//   m_bus        shared master port towards the AXI bridge (master modport)
//   proto_err    sticky: response with nothing outstanding, or a requester
//                dropped req while its address phase was locked
// Parameters: OUTSTANDING order-FIFO depth (power of 2, >= 2), ADDR_W, DATA_W.
// Configuration: define SRAM_ARB_RR_EN for round-robin arbitration between
// the two requesters; otherwise data has fixed priority over inst.
// ----------------------------------------------------------------------------
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int CNT_W      = $clog2(OUTSTANDING) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_arbiter_if.slave   inst_bus,
    sram_like_arbiter_if.slave   data_bus,
    sram_like_arbiter_if.master  m_bus,
    output logic                 proto_err
);

    logic             r_lock_valid;
    logic             r_lock_id;
    logic             r_proto_err;
`ifdef SRAM_ARB_RR_EN
    logic             r_last_id;
`endif

    logic             w_gnt_id;
    logic             w_sel_req;
    logic             w_m_req;
    logic             w_push;
    logic             w_pop;
    logic             w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_stray_rsp;
    logic             w_lock_drop;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_id = ID_INST;
        if (r_lock_valid) begin
            w_gnt_id = r_lock_id;
        end else if (data_bus.req && inst_bus.req) begin
`ifdef SRAM_ARB_RR_EN
            w_gnt_id = ~r_last_id;
`else
            w_gnt_id = ID_DATA;
`endif
        end else if (data_bus.req) begin
            w_gnt_id = ID_DATA;
        end
        w_sel_req = (w_gnt_id == ID_DATA) ? data_bus.req : inst_bus.req;
        // Full blocks even when a pop happens this cycle.
        w_m_req   = w_sel_req & ~w_full;
    end

    // ------------------------------------------------------------------
    // Master-port request mux; all fields zero when nothing is granted
    // ------------------------------------------------------------------
    always_comb begin
        m_bus.req   = w_m_req;
        m_bus.wr    = 1'b0;
        m_bus.size  = SZ_BYTE;
        m_bus.addr  = {ADDR_W{1'b0}};
        m_bus.wdata = {DATA_W{1'b0}};
        if (w_m_req) begin
            if (w_gnt_id == ID_DATA) begin
                m_bus.wr    = data_bus.wr;
                m_bus.size  = data_bus.size;
                m_bus.addr  = data_bus.addr;
                m_bus.wdata = data_bus.wdata;
            end else begin
                m_bus.wr    = inst_bus.wr;
                m_bus.size  = inst_bus.size;
                m_bus.addr  = inst_bus.addr;
                m_bus.wdata = inst_bus.wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake steering
    // ------------------------------------------------------------------
    assign w_push = w_m_req & m_bus.addr_ok;
    assign w_pop  = m_bus.data_ok & ~w_empty;

    assign inst_bus.addr_ok = w_push & (w_gnt_id == ID_INST);
    assign data_bus.addr_ok = w_push & (w_gnt_id == ID_DATA);

    assign inst_bus.data_ok = w_pop & (w_head == ID_INST);
    assign data_bus.data_ok = w_pop & (w_head == ID_DATA);

    assign inst_bus.rdata = m_bus.rdata;
    assign data_bus.rdata = m_bus.rdata;

    // A response with nothing outstanding, or the locked requester
    // withdrawing its request, is a protocol violation.
    assign w_stray_rsp = m_bus.data_ok & w_empty;
    assign w_lock_drop = r_lock_valid & ~w_sel_req;

    assign proto_err = r_proto_err;

    arb_order_fifo #(
        .OUTSTANDING (OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_push),
        .i_push_id (w_gnt_id),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // ------------------------------------------------------------------
    // Lock and error state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lock_valid <= 1'b0;
            r_lock_id    <= ID_INST;
            r_proto_err  <= 1'b0;
        end else begin
            // A pending address phase pins the grant until it is accepted.
            if (w_m_req && !m_bus.addr_ok) begin
                r_lock_valid <= 1'b1;
                r_lock_id    <= w_gnt_id;
            end else if (w_m_req || w_lock_drop) begin
                r_lock_valid <= 1'b0;
            end
            if (w_stray_rsp || w_lock_drop) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_id <= ID_INST;
        end else if (w_push) begin
            r_last_id <= w_gnt_id;
        end
    end
`endif

    // The order FIFO can never hold more entries than it has slots.
    a_count_bound : assert property (@(posedge clk) disable iff (!resetn)
        w_count <= CNT_W'(OUTSTANDING));

endmodule : sram_like_arbiter

// File: tb/tb_sram_like_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_like_arbiter
// Directed, self-checking bench for sram_like_arbiter. Inputs are driven 1 ns
// after the rising edge and outputs are sampled 1 ns later, well away from
// the next edge. Each scenario task compares observed outputs against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_sram_like_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk;
    logic resetn;
    logic proto_err;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    sram_like_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) inst_bus ();
    sram_like_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) data_bus ();
    sram_like_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

    sram_like_arbiter #(
        .OUTSTANDING (4),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_bus  (inst_bus),
        .data_bus  (data_bus),
        .m_bus     (m_bus),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        inst_bus.req   = 1'b0;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = SZ_WORD;
        inst_bus.addr  = '0;
        inst_bus.wdata = '0;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.size  = SZ_WORD;
        data_bus.addr  = '0;
        data_bus.wdata = '0;
        m_bus.rdata    = '0;
        m_bus.addr_ok  = 1'b0;
        m_bus.data_ok  = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        m_bus.addr_ok = 1'b1;
        #1;
        vec_cnt++;
        if (m_bus.req !== 1'b0) begin miscmp_cnt++; $display("FAIL reset_m_req: got %b want 0", m_bus.req); end
        vec_cnt++;
        if ({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok} !== 4'b0000) begin
            miscmp_cnt++;
            $display("FAIL reset_oks: got %b want 0000",
                     {inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok});
        end
        vec_cnt++;
        if (proto_err !== 1'b0) begin miscmp_cnt++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        vec_cnt++;
        if (m_bus.addr !== 32'h0) begin miscmp_cnt++; $display("FAIL reset_m_addr: got %h want 0", m_bus.addr); end
        step();
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_inst();
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'hBFC0_0000;
        m_bus.addr_ok = 1'b1;
        #1;
        vec_cnt++;
        if (m_bus.addr !== 32'hBFC0_0000) begin miscmp_cnt++; $display("FAIL single_m_addr: got %h want bfc00000", m_bus.addr); end
        vec_cnt++;
        if (inst_bus.addr_ok !== 1'b1) begin miscmp_cnt++; $display("FAIL single_inst_addr_ok: got %b want 1", inst_bus.addr_ok); end
        step();
        drive_idle();
        #1;
        vec_cnt++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
            miscmp_cnt++; $display("FAIL single_c1_data_ok: got %b want 00", {inst_bus.data_ok, data_bus.data_ok});
        end
        step();
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'h3C08_0001;
        #1;
        vec_cnt++;
        if (inst_bus.data_ok !== 1'b1) begin miscmp_cnt++; $display("FAIL single_inst_data_ok: got %b want 1", inst_bus.data_ok); end
        vec_cnt++;
        if (inst_bus.rdata !== 32'h3C08_0001) begin miscmp_cnt++; $display("FAIL single_inst_rdata: got %h want 3c080001", inst_bus.rdata); end
        vec_cnt++;
        if (data_bus.data_ok !== 1'b0) begin miscmp_cnt++; $display("FAIL single_data_data_ok: got %b want 0", data_bus.data_ok); end
        step();
        drive_idle();
        #1;
        vec_cnt++;
        if (inst_bus.data_ok !== 1'b0) begin miscmp_cnt++; $display("FAIL single_pulse_width: got %b want 0", inst_bus.data_ok); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        inst_bus.req   = 1'b1;
        inst_bus.addr  = 32'h0040_0000;
        data_bus.req   = 1'b1;
        data_bus.wr    = 1'b1;
        data_bus.addr  = 32'h8000_1000;
        data_bus.wdata = 32'h1234_5678;
        m_bus.addr_ok  = 1'b1;
        #1;
        vec_cnt++;
        if (m_bus.addr !== 32'h8000_1000) begin miscmp_cnt++; $display("FAIL prio_first_addr: got %h want 80001000", m_bus.addr); end
        vec_cnt++;
        if ({m_bus.wr, m_bus.wdata} !== {1'b1, 32'h1234_5678}) begin
            miscmp_cnt++; $display("FAIL prio_first_wr_wdata: got %b/%h want 1/12345678", m_bus.wr, m_bus.wdata);
        end
        vec_cnt++;
        if ({data_bus.addr_ok, inst_bus.addr_ok} !== 2'b10) begin
            miscmp_cnt++; $display("FAIL prio_first_oks: got %b want 10", {data_bus.addr_ok, inst_bus.addr_ok});
        end
        step();
        data_bus.req = 1'b0;
        data_bus.wr  = 1'b0;
        #1;
        vec_cnt++;
        if (m_bus.addr !== 32'h0040_0000) begin miscmp_cnt++; $display("FAIL prio_second_addr: got %h want 00400000", m_bus.addr); end
        vec_cnt++;
        if ({data_bus.addr_ok, inst_bus.addr_ok, m_bus.wr} !== 3'b010) begin
            miscmp_cnt++; $display("FAIL prio_second_oks: got %b want 010", {data_bus.addr_ok, inst_bus.addr_ok, m_bus.wr});
        end
        step();
        drive_idle();
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'hAAAA_0001;
        #1;
        vec_cnt++;
        if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b10) begin
            miscmp_cnt++; $display("FAIL prio_rsp1: got %b want 10", {data_bus.data_ok, inst_bus.data_ok});
        end
        step();
        m_bus.rdata = 32'hBBBB_0002;
        #1;
        vec_cnt++;
        if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b01) begin
            miscmp_cnt++; $display("FAIL prio_rsp2: got %b want 01", {data_bus.data_ok, inst_bus.data_ok});
        end
        vec_cnt++;
        if (inst_bus.rdata !== 32'hBBBB_0002) begin miscmp_cnt++; $display("FAIL prio_rsp2_rdata: got %h want bbbb0002", inst_bus.rdata); end
        step();
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock();
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'h0040_0010;
        data_bus.addr = 32'h8000_2000;
        for (int c = 0; c < 4; c++) begin
            data_bus.req  = (c >= 1);
            m_bus.addr_ok = (c == 3);
            #1;
            vec_cnt++;
            if (m_bus.addr !== 32'h0040_0010) begin
                miscmp_cnt++; $display("FAIL lock_addr_c%0d: got %h want 00400010", c, m_bus.addr);
            end
            vec_cnt++;
            if ({inst_bus.addr_ok, data_bus.addr_ok} !== {(c == 3), 1'b0}) begin
                miscmp_cnt++; $display("FAIL lock_oks_c%0d: got %b want %b", c,
                                       {inst_bus.addr_ok, data_bus.addr_ok}, {(c == 3), 1'b0});
            end
            step();
        end
        inst_bus.req = 1'b0;
        #1;
        vec_cnt++;
        if ({m_bus.addr, data_bus.addr_ok} !== {32'h8000_2000, 1'b1}) begin
            miscmp_cnt++; $display("FAIL lock_release: got %h/%b want 80002000/1", m_bus.addr, data_bus.addr_ok);
        end
        step();
        drive_idle();
        m_bus.data_ok = 1'b1;
        #1;
        vec_cnt++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin
            miscmp_cnt++; $display("FAIL lock_rsp1: got %b want 10", {inst_bus.data_ok, data_bus.data_ok});
        end
        step();
        #1;
        vec_cnt++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b01) begin
            miscmp_cnt++; $display("FAIL lock_rsp2: got %b want 01", {inst_bus.data_ok, data_bus.data_ok});
        end
        vec_cnt++;
        if (proto_err !== 1'b0) begin miscmp_cnt++; $display("FAIL lock_proto_err: got %b want 0", proto_err); end
        step();
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        // Cycles 0-3 fill, 4 blocked, 5 pop while full (still blocked),
        // 6 refill, 7-10 drain.
        for (int c = 0; c < 11; c++) begin
            inst_bus.req  = (c <= 6);
            inst_bus.addr = 32'h0000_2000 + 32'(c) * 4;
            m_bus.addr_ok = (c <= 6);
            m_bus.data_ok = (c == 5) || (c >= 7);
            #1;
            vec_cnt++;
            if (m_bus.req !== ((c <= 3) || (c == 6))) begin
                miscmp_cnt++; $display("FAIL full_m_req_c%0d: got %b want %b", c, m_bus.req, ((c <= 3) || (c == 6)));
            end
            vec_cnt++;
            if (inst_bus.data_ok !== ((c == 5) || (c >= 7))) begin
                miscmp_cnt++; $display("FAIL full_data_ok_c%0d: got %b want %b", c, inst_bus.data_ok, ((c == 5) || (c >= 7)));
            end
            step();
        end
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        logic pat [10];
        logic [31:0] exp_addr;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            exp_addr       = 32'h0000_3000 + 32'(i) * 4;
            inst_bus.req   = (i < 10) && (pat[i % 10] == ID_INST);
            data_bus.req   = (i < 10) && (pat[i % 10] == ID_DATA);
            inst_bus.addr  = exp_addr;
            data_bus.addr  = exp_addr;
            m_bus.addr_ok  = (i < 10);
            m_bus.data_ok  = (i >= 2);
            #1;
            if (i < 10) begin
                vec_cnt++;
                if ({m_bus.addr, inst_bus.addr_ok, data_bus.addr_ok} !==
                    {exp_addr, (pat[i] == ID_INST), (pat[i] == ID_DATA)}) begin
                    miscmp_cnt++; $display("FAIL wrap_accept_%0d: got %h/%b%b want %h/%b%b", i, m_bus.addr,
                                           inst_bus.addr_ok, data_bus.addr_ok, exp_addr,
                                           (pat[i] == ID_INST), (pat[i] == ID_DATA));
                end
            end
            if (i >= 2) begin
                vec_cnt++;
                if ({inst_bus.data_ok, data_bus.data_ok} !== {(pat[i-2] == ID_INST), (pat[i-2] == ID_DATA)}) begin
                    miscmp_cnt++; $display("FAIL wrap_rsp_%0d: got %b%b want %b%b", i, inst_bus.data_ok,
                                           data_bus.data_ok, (pat[i-2] == ID_INST), (pat[i-2] == ID_DATA));
                end
            end
            step();
        end
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_proto_err();
        m_bus.data_ok = 1'b1;
        #1;
        vec_cnt++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
            miscmp_cnt++; $display("FAIL stray_data_ok: got %b want 00", {inst_bus.data_ok, data_bus.data_ok});
        end
        step();
        m_bus.data_ok = 1'b0;
        #1;
        vec_cnt++;
        if (proto_err !== 1'b1) begin miscmp_cnt++; $display("FAIL stray_proto_err: got %b want 1", proto_err); end
        // Two accepted transactions left in flight, then reset.
        inst_bus.req  = 1'b1;
        m_bus.addr_ok = 1'b1;
        step();
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1;
        step();
        vec_cnt++;
        if (proto_err !== 1'b1) begin miscmp_cnt++; $display("FAIL sticky_proto_err: got %b want 1", proto_err); end
        do_reset();
        #1;
        vec_cnt++;
        if ({m_bus.req, proto_err} !== 2'b00) begin
            miscmp_cnt++; $display("FAIL midreset_req_err: got %b want 00", {m_bus.req, proto_err});
        end
        // Cleared count: exactly four accepts fit before the fifth blocks.
        inst_bus.req  = 1'b1;
        m_bus.addr_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec_cnt++;
            if (inst_bus.addr_ok !== (c < 4)) begin
                miscmp_cnt++; $display("FAIL midreset_fill_c%0d: got %b want %b", c, inst_bus.addr_ok, (c < 4));
            end
            step();
        end
        drive_idle();
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock_drop();
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'h0040_0020;
        step();
        inst_bus.req  = 1'b0;
        data_bus.req  = 1'b1;
        data_bus.addr = 32'h8000_3000;
        m_bus.addr_ok = 1'b1;
        #1;
        vec_cnt++;
        if ({m_bus.req, data_bus.addr_ok} !== 2'b00) begin
            miscmp_cnt++; $display("FAIL drop_blocked: got %b want 00", {m_bus.req, data_bus.addr_ok});
        end
        step();
        #1;
        vec_cnt++;
        if ({proto_err, data_bus.addr_ok, m_bus.addr} !== {1'b1, 1'b1, 32'h8000_3000}) begin
            miscmp_cnt++; $display("FAIL drop_after: got %b/%b/%h want 1/1/80003000", proto_err, data_bus.addr_ok, m_bus.addr);
        end
        step();
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_both_held();
        logic exp_gnt [6];
`ifdef SRAM_ARB_RR_EN
        exp_gnt = '{ID_DATA, ID_INST, ID_DATA, ID_INST, ID_DATA, ID_INST};
`else
        exp_gnt = '{ID_DATA, ID_DATA, ID_DATA, ID_DATA, ID_DATA, ID_DATA};
`endif
        inst_bus.addr = 32'h0040_0100;
        data_bus.addr = 32'h8000_0100;
        for (int i = 0; i < 8; i++) begin
            inst_bus.req  = (i < 6);
            data_bus.req  = (i < 6);
            m_bus.addr_ok = (i < 6);
            m_bus.data_ok = (i >= 2);
            #1;
            if (i < 6) begin
                vec_cnt++;
                if ({data_bus.addr_ok, inst_bus.addr_ok} !== {(exp_gnt[i] == ID_DATA), (exp_gnt[i] == ID_INST)}) begin
                    miscmp_cnt++; $display("FAIL both_grant_%0d: got %b%b want %b%b", i, data_bus.addr_ok,
                                           inst_bus.addr_ok, (exp_gnt[i] == ID_DATA), (exp_gnt[i] == ID_INST));
                end
            end
            if (i >= 2) begin
                vec_cnt++;
                if ({data_bus.data_ok, inst_bus.data_ok} !== {(exp_gnt[i-2] == ID_DATA), (exp_gnt[i-2] == ID_INST)}) begin
                    miscmp_cnt++; $display("FAIL both_rsp_%0d: got %b%b want %b%b", i, data_bus.data_ok,
                                           inst_bus.data_ok, (exp_gnt[i-2] == ID_DATA), (exp_gnt[i-2] == ID_INST));
                end
            end
            step();
        end
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    initial begin
        resetn = 1'b0;
        drive_idle();
        step();
        test_reset();
        test_single_inst();
        test_priority();
        test_lock();
        test_full();
        test_wrap();
        test_proto_err();
        test_lock_drop();
        test_both_held();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule : tb_sram_like_arbiter
